sequencia_tx: RTL and testbench

Serial word generator: the transmitting counterpart of the serial sequence detector. It holds a programmable WIDTH-bit pattern and, on a start request, shifts it out MSB-first, one bit per clock, for a programmable number of repetitions. Consecutive repetitions are separated by a programmable idle gap. Its bit_out drives a detector's bit_in directly, both on the bench and in loop-back designs.

---
 rtl/sequencia_pkg.sv | 12 +
 rtl/sequencia_tx_shift.sv | 35 +++
 rtl/sequencia_tx.sv | 152 +++++++++++++++
 tb/tb_sequencia_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencia_pkg.sv
// Shared definitions for the serial word generator and its matching detector.
package sequencia_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/sequencia_tx_shift.sv
// Parallel-load left shift register; the MSB is the next serial bit to leave.
module sequencia_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (load) begin
            shift_d = din;
        end else if (shift_en) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign msb = shift_q[WIDTH-1];

endmodule

// File: rtl/sequencia_tx.sv
// Serial word generator: sends a stored pattern MSB-first a programmable number
// of times, with a programmable idle gap between consecutive words.
module sequencia_tx
    import sequencia_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             setar_palavra,
    input  logic [WIDTH-1:0] palavra,
    input  logic             start,
    input  logic [REP_W-1:0] repeticoes,
    input  logic [GAP_W-1:0] intervalo,
    input  logic             abortar,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             ocupado,
    output logic             concluido
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_t state_q, state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [REP_W-1:0] word_cnt_q, word_cnt_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             concluido_q, concluido_d;

    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_din;
    logic             sh_msb;

    sequencia_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .shift_en (sh_shift),
        .din      (sh_din),
        .msb      (sh_msb)
    );

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        word_cnt_d  = word_cnt_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        concluido_d = 1'b0;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_din      = pattern_q;

        case (state_q)
            IDLE: begin
                if (setar_palavra) begin
                    pattern_d = palavra;
                end
                // A pattern written in the start cycle is the one sent.
                if (start && !abortar) begin
                    sh_load    = 1'b1;
                    sh_din     = setar_palavra ? palavra : pattern_q;
                    word_cnt_d = (repeticoes == '0) ? REP_W'(1) : repeticoes;
                    gap_len_d  = intervalo;
                    gap_cnt_d  = '0;
                    bit_cnt_d  = BIT_LAST;
                    state_d    = SEND;
                end
            end

            SEND: begin
                if (abortar) begin
                    word_cnt_d = '0;
                    gap_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    state_d    = IDLE;
                end else if (bit_cnt_q == '0) begin
                    word_cnt_d = word_cnt_q - REP_W'(1);
                    if (word_cnt_q == REP_W'(1)) begin
                        concluido_d = 1'b1;
                        state_d     = IDLE;
                    end else if (gap_len_q != '0) begin
                        gap_cnt_d = gap_len_q;
                        state_d   = GAP;
                    end else begin
                        sh_load   = 1'b1;
                        bit_cnt_d = BIT_LAST;
                    end
                end else begin
                    sh_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end
            end

            GAP: begin
                if (abortar) begin
                    word_cnt_d = '0;
                    gap_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    state_d    = IDLE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    sh_load   = 1'b1;
                    bit_cnt_d = BIT_LAST;
                    state_d   = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            word_cnt_q  <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            concluido_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            word_cnt_q  <= word_cnt_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            concluido_q <= concluido_d;
        end
    end

    // All outputs decode registered state only.
    assign bit_valid = (state_q == SEND);
    assign bit_out   = (state_q == SEND) & sh_msb;
    assign ocupado   = (state_q != IDLE);
    assign concluido = concluido_q;

endmodule

// File: tb/tb_sequencia_tx.sv
// Directed bench for the serial word generator: bit streams, gaps, repeats,
// ignored requests while busy, abort, asynchronous reset and a loop-back check.
module tb_sequencia_tx;

    logic       clk;
    logic       rst_n;
    logic       setar_palavra;
    logic [7:0] palavra;
    logic       start;
    logic [3:0] repeticoes;
    logic [3:0] intervalo;
    logic       abortar;
    logic       bit_out;
    logic       bit_valid;
    logic       ocupado;
    logic       concluido;

    int checks   = 0;
    int failures = 0;

    sequencia_tx #(
        .WIDTH (8),
        .REP_W (4),
        .GAP_W (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .setar_palavra (setar_palavra),
        .palavra       (palavra),
        .start         (start),
        .repeticoes    (repeticoes),
        .intervalo     (intervalo),
        .abortar       (abortar),
        .bit_out       (bit_out),
        .bit_valid     (bit_valid),
        .ocupado       (ocupado),
        .concluido     (concluido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge where the MSB is visible.
    task automatic start_tx(input logic [7:0] word, input logic [3:0] rep,
                            input logic [3:0] gap, input logic load);
        setar_palavra = load;
        palavra       = word;
        start         = 1'b1;
        repeticoes    = rep;
        intervalo     = gap;
        @(negedge clk);
        setar_palavra = 1'b0;
        start         = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bit_out !== 1'b0)   begin failures++; $display("[TB] FAIL reset_bit_out got=%b exp=0", bit_out); end
        checks++; if (bit_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_bit_valid got=%b exp=0", bit_valid); end
        checks++; if (ocupado !== 1'b0)   begin failures++; $display("[TB] FAIL reset_ocupado got=%b exp=0", ocupado); end
        checks++; if (concluido !== 1'b0) begin failures++; $display("[TB] FAIL reset_concluido got=%b exp=0", concluido); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] exp_bits;
        exp_bits = 8'b1011_0101;
        start_tx(8'hB5, 4'd1, 4'd0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            checks++; if (bit_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid c=%0d got=%b exp=1", c, bit_valid); end
            checks++; if (bit_out !== exp_bits[7-c]) begin failures++; $display("[TB] FAIL single_bit c=%0d got=%b exp=%b", c, bit_out, exp_bits[7-c]); end
            checks++; if (ocupado !== 1'b1) begin failures++; $display("[TB] FAIL single_busy c=%0d got=%b exp=1", c, ocupado); end
            checks++; if (concluido !== 1'b0) begin failures++; $display("[TB] FAIL single_early_done c=%0d got=%b exp=0", c, concluido); end
            @(negedge clk);
        end
        checks++; if (concluido !== 1'b1) begin failures++; $display("[TB] FAIL single_done got=%b exp=1", concluido); end
        checks++; if (ocupado !== 1'b0)   begin failures++; $display("[TB] FAIL single_idle got=%b exp=0", ocupado); end
        checks++; if (bit_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_end got=%b exp=0", bit_valid); end
        @(negedge clk);
        checks++; if (concluido !== 1'b0) begin failures++; $display("[TB] FAIL single_done_pulse got=%b exp=0", concluido); end
    endtask

    task automatic test_repeat();
        logic [7:0] word;
        int         p;
        logic       ev;
        logic       eb;
        int         done_cnt;
        word     = 8'hF0;
        done_cnt = 0;
        start_tx(word, 4'd3, 4'd2, 1'b1);
        for (int c = 0; c < 28; c++) begin
            p  = c % 10;
            ev = (p < 8);
            eb = ev ? word[7-p] : 1'b0;
            checks++; if (bit_valid !== ev) begin failures++; $display("[TB] FAIL repeat_valid c=%0d got=%b exp=%b", c, bit_valid, ev); end
            checks++; if (bit_out !== eb)   begin failures++; $display("[TB] FAIL repeat_bit c=%0d got=%b exp=%b", c, bit_out, eb); end
            checks++; if (ocupado !== 1'b1) begin failures++; $display("[TB] FAIL repeat_busy c=%0d got=%b exp=1", c, ocupado); end
            if (concluido === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checks++; if (done_cnt !== 0)     begin failures++; $display("[TB] FAIL repeat_early_done got=%0d exp=0", done_cnt); end
        checks++; if (concluido !== 1'b1) begin failures++; $display("[TB] FAIL repeat_done got=%b exp=1", concluido); end
        checks++; if (ocupado !== 1'b0)   begin failures++; $display("[TB] FAIL repeat_idle got=%b exp=0", ocupado); end
        @(negedge clk);
        checks++; if (concluido !== 1'b0) begin failures++; $display("[TB] FAIL repeat_done_pulse got=%b exp=0", concluido); end
    endtask

    task automatic test_rep_zero();
        logic [7:0] w1;
        logic [7:0] w2;
        w1 = 8'hB5;
        w2 = 8'h3C;
        start_tx(w1, 4'd0, 4'd0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            checks++; if (bit_valid !== 1'b1)   begin failures++; $display("[TB] FAIL rep0_valid c=%0d got=%b exp=1", c, bit_valid); end
            checks++; if (bit_out !== w1[7-c]) begin failures++; $display("[TB] FAIL rep0_bit c=%0d got=%b exp=%b", c, bit_out, w1[7-c]); end
            @(negedge clk);
        end
        checks++; if (concluido !== 1'b1) begin failures++; $display("[TB] FAIL rep0_done got=%b exp=1", concluido); end
        checks++; if (ocupado !== 1'b0)   begin failures++; $display("[TB] FAIL rep0_idle got=%b exp=0", ocupado); end
        start_tx(w2, 4'd2, 4'd0, 1'b1);
        for (int c = 0; c < 16; c++) begin
            checks++; if (bit_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid c=%0d got=%b exp=1", c, bit_valid); end
            checks++; if (bit_out !== w2[7-(c%8)]) begin failures++; $display("[TB] FAIL b2b_bit c=%0d got=%b exp=%b", c, bit_out, w2[7-(c%8)]); end
            checks++; if (concluido !== 1'b0) begin failures++; $display("[TB] FAIL b2b_early_done c=%0d got=%b exp=0", c, concluido); end
            @(negedge clk);
        end
        checks++; if (concluido !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done got=%b exp=1", concluido); end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        start_tx(8'hFF, 4'd1, 4'd0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            checks++; if (bit_out !== 1'b1) begin failures++; $display("[TB] FAIL ignore_bit c=%0d got=%b exp=1", c, bit_out); end
            checks++; if (bit_valid !== 1'b1) begin failures++; $display("[TB] FAIL ignore_valid c=%0d got=%b exp=1", c, bit_valid); end
            if (c == 2) begin
                setar_palavra = 1'b1;
                palavra       = 8'h00;
                start         = 1'b1;
            end else if (c == 3) begin
                setar_palavra = 1'b0;
                start         = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (concluido !== 1'b1) begin failures++; $display("[TB] FAIL ignore_done got=%b exp=1", concluido); end
        checks++; if (ocupado !== 1'b0)   begin failures++; $display("[TB] FAIL ignore_idle got=%b exp=0", ocupado); end
        start_tx(8'h00, 4'd1, 4'd0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            checks++; if (bit_valid !== 1'b1) begin failures++; $display("[TB] FAIL restart_valid c=%0d got=%b exp=1", c, bit_valid); end
            checks++; if (bit_out !== 1'b1)   begin failures++; $display("[TB] FAIL restart_bit c=%0d got=%b exp=1", c, bit_out); end
            @(negedge clk);
        end
        checks++; if (concluido !== 1'b1) begin failures++; $display("[TB] FAIL restart_done got=%b exp=1", concluido); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [7:0] word;
        int         p;
        logic       ev;
        logic       eb;
        int         done_cnt;
        word     = 8'hA5;
        done_cnt = 0;
        start_tx(word, 4'd3, 4'd1, 1'b1);
        for (int c = 0; c <= 12; c++) begin
            p  = c % 9;
            ev = (p < 8);
            eb = ev ? word[7-p] : 1'b0;
            checks++; if (bit_valid !== ev) begin failures++; $display("[TB] FAIL abort_pre_valid c=%0d got=%b exp=%b", c, bit_valid, ev); end
            checks++; if (bit_out !== eb)   begin failures++; $display("[TB] FAIL abort_pre_bit c=%0d got=%b exp=%b", c, bit_out, eb); end
            if (c == 12) abortar = 1'b1;
            @(negedge clk);
        end
        abortar = 1'b0;
        checks++; if (bit_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_valid got=%b exp=0", bit_valid); end
        checks++; if (ocupado !== 1'b0)   begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", ocupado); end
        for (int c = 0; c < 4; c++) begin
            if (concluido === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checks++; if (done_cnt !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d exp=0", done_cnt); end
        start_tx(8'h00, 4'd1, 4'd0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            checks++; if (bit_out !== word[7-c]) begin failures++; $display("[TB] FAIL abort_kept_bit c=%0d got=%b exp=%b", c, bit_out, word[7-c]); end
            @(negedge clk);
        end
        checks++; if (concluido !== 1'b1) begin failures++; $display("[TB] FAIL abort_kept_done got=%b exp=1", concluido); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start_tx(8'h5A, 4'd1, 4'd0, 1'b1);
        checks++; if (bit_out !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_bit0 got=%b exp=0", bit_out); end
        @(negedge clk);
        checks++; if (bit_out !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_bit1 got=%b exp=1", bit_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (bit_out !== 1'b0)   begin failures++; $display("[TB] FAIL rstmid_bit_out got=%b exp=0", bit_out); end
        checks++; if (bit_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b exp=0", bit_valid); end
        checks++; if (ocupado !== 1'b0)   begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", ocupado); end
        checks++; if (concluido !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done got=%b exp=0", concluido); end
        @(negedge clk);
        rst_n = 1'b1;
        start_tx(8'h00, 4'd1, 4'd0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            checks++; if (bit_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_zero_valid c=%0d got=%b exp=1", c, bit_valid); end
            checks++; if (bit_out !== 1'b0)   begin failures++; $display("[TB] FAIL rstmid_zero_bit c=%0d got=%b exp=0", c, bit_out); end
            @(negedge clk);
        end
        checks++; if (concluido !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_zero_done got=%b exp=1", concluido); end
        @(negedge clk);
    endtask

    task automatic test_loopback();
        logic [7:0] det;
        logic       found;
        det = 8'h00;
        start_tx(8'hC3, 4'd1, 4'd0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            if (bit_valid === 1'b1) det = {det[6:0], bit_out};
            found = (det == 8'hC3);
            if (c == 6) begin
                checks++; if (found !== 1'b0) begin failures++; $display("[TB] FAIL loop_early_found got=%b exp=0", found); end
            end
            @(negedge clk);
        end
        found = (det == 8'hC3);
        checks++; if (found !== 1'b1) begin failures++; $display("[TB] FAIL loop_found got=%b exp=1 det=%h", found, det); end
        checks++; if (concluido !== 1'b1) begin failures++; $display("[TB] FAIL loop_done got=%b exp=1", concluido); end
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b1;
        setar_palavra = 1'b0;
        palavra       = 8'h00;
        start         = 1'b0;
        repeticoes    = 4'd0;
        intervalo     = 4'd0;
        abortar       = 1'b0;
        test_reset();
        test_single();
        test_repeat();
        test_rep_zero();
        test_ignore_busy();
        test_abort();
        test_reset_mid();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
